lif_step_unit: RTL and testbench



---
 rtl/lif_step_unit.sv | 276 +++++++++++++++++++++++++++
 tb/tb_lif_step_unit.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lif_step_unit.sv
// lif_step_unit: one leaky integrate-and-fire Euler step per accepted sample (sign-magnitude Q16.16).
// Latency: 6 cycles from input handshake to out_valid; one sample per 7 cycles at best.
// Backpressure: a held result (out_valid && !out_ready) stalls the next step in CMP; in_ready drops while busy.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid / in_ready        input handshake; in_ready is high only in IDLE
//   i_in                       input current
//   v_rest, v_reset, v_th      resting potential, post-spike potential, firing threshold
//   r_mem, dt_tau              membrane resistance, dt/tau scale
//   refrac_steps               steps held after a spike
//   out_valid / out_ready      output handshake
//   v_out, spike               membrane voltage after the step, spike flag
module lif_step_unit #(
    parameter int N  = 32,
    parameter int Q  = 16,
    parameter int RW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  i_in,
    input  logic [N-1:0]  v_rest,
    input  logic [N-1:0]  v_reset,
    input  logic [N-1:0]  v_th,
    input  logic [N-1:0]  r_mem,
    input  logic [N-1:0]  dt_tau,
    input  logic [RW-1:0] refrac_steps,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  v_out,
    output logic          spike
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DIFF,
        S_DRIVE,
        S_SUM,
        S_SCALE,
        S_ACC,
        S_CMP
    } state_t;

    state_t state_q, state_d;

    // Sampled operands, captured with -0 folded to +0.
    logic [N-1:0]  i_in_q, i_in_d;
    logic [N-1:0]  v_rest_q, v_rest_d;
    logic [N-1:0]  v_reset_q, v_reset_d;
    logic [N-1:0]  v_th_q, v_th_d;
    logic [N-1:0]  r_mem_q, r_mem_d;
    logic [N-1:0]  dt_tau_q, dt_tau_d;
    logic [RW-1:0] refrac_q, refrac_d;

    // Neuron state.
    logic [N-1:0]  v_q, v_d;
    logic [RW-1:0] rc_q, rc_d;

    // Step temporaries: sum_q holds d, then s, then vn; prod_q holds p, then q.
    logic [N-1:0]  sum_q, sum_d;
    logic [N-1:0]  prod_q, prod_d;

    // Output registers.
    logic          out_valid_q, out_valid_d;
    logic [N-1:0]  v_out_q, v_out_d;
    logic          spike_q, spike_d;

    function automatic logic [N-1:0] norm_zero(input logic [N-1:0] x);
        return (x[N-2:0] == '0) ? '0 : x;
    endfunction

    // ------------------------------------------------------------------
    // Shared operator operand selection
    // ------------------------------------------------------------------
    logic [N-1:0] neg_v;
    logic [N-1:0] add_a, add_b, add_y;
    logic [N-1:0] mul_a, mul_b, mul_y;

    always_comb begin
        // Negation flips the sign only for non-zero values so -0 never appears.
        neg_v = (v_q[N-2:0] == '0) ? '0 : {~v_q[N-1], v_q[N-2:0]};

        add_a = v_rest_q;
        add_b = neg_v;
        mul_a = r_mem_q;
        mul_b = i_in_q;
        case (state_q)
            S_SUM: begin
                add_a = sum_q;
                add_b = prod_q;
            end
            S_ACC: begin
                add_a = v_q;
                add_b = prod_q;
            end
            S_SCALE: begin
                mul_a = dt_tau_q;
                mul_b = sum_q;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Shared sign-magnitude adder: magnitude wraps, zero always positive
    // ------------------------------------------------------------------
    logic [N-2:0] add_mag;
    logic         add_sgn;

    always_comb begin
        add_sgn = add_a[N-1];
        add_mag = add_a[N-2:0] + add_b[N-2:0];
        if (add_a[N-1] != add_b[N-1]) begin
            if (add_a[N-2:0] >= add_b[N-2:0]) begin
                add_mag = add_a[N-2:0] - add_b[N-2:0];
                add_sgn = add_a[N-1];
            end else begin
                add_mag = add_b[N-2:0] - add_a[N-2:0];
                add_sgn = add_b[N-1];
            end
        end
        add_y = (add_mag == '0) ? '0 : {add_sgn, add_mag};
    end

    // ------------------------------------------------------------------
    // Shared sign-magnitude multiplier: (|a|*|b|) >> Q, truncated
    // ------------------------------------------------------------------
    logic [2*N-3:0] mul_full;
    logic [N-2:0]   mul_mag;
    logic           mul_unused;

    always_comb begin
        mul_full = {{(N-1){1'b0}}, mul_a[N-2:0]} * {{(N-1){1'b0}}, mul_b[N-2:0]};
        mul_mag  = mul_full[Q +: N-1];
        mul_y    = (mul_mag == '0) ? '0 : {mul_a[N-1] ^ mul_b[N-1], mul_mag};
    end

    // Integer bits above the Q16.16 window and sub-LSB fraction are discarded.
    assign mul_unused = ^{mul_full[2*N-3:Q+N-1], mul_full[Q-1:0]};

    // ------------------------------------------------------------------
    // Comparator: vn >= v_th in two's-complement view, +0 == -0
    // ------------------------------------------------------------------
    logic signed [N:0] vn_val, th_val;
    logic              cmp_ge;

    always_comb begin
        vn_val = $signed({2'b00, sum_q[N-2:0]});
        th_val = $signed({2'b00, v_th_q[N-2:0]});
        if (sum_q[N-1])  vn_val = -vn_val;
        if (v_th_q[N-1]) th_val = -th_val;
        cmp_ge = (vn_val >= th_val);
    end

    // ------------------------------------------------------------------
    // FSM next state and datapath updates
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        i_in_d      = i_in_q;
        v_rest_d    = v_rest_q;
        v_reset_d   = v_reset_q;
        v_th_d      = v_th_q;
        r_mem_d     = r_mem_q;
        dt_tau_d    = dt_tau_q;
        refrac_d    = refrac_q;
        v_d         = v_q;
        rc_d        = rc_q;
        sum_d       = sum_q;
        prod_d      = prod_q;
        v_out_d     = v_out_q;
        spike_d     = spike_q;
        // A consumed result drops valid unless CMP reloads it below.
        out_valid_d = out_valid_q & ~out_ready;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    i_in_d    = norm_zero(i_in);
                    v_rest_d  = norm_zero(v_rest);
                    v_reset_d = norm_zero(v_reset);
                    v_th_d    = norm_zero(v_th);
                    r_mem_d   = norm_zero(r_mem);
                    dt_tau_d  = norm_zero(dt_tau);
                    refrac_d  = refrac_steps;
                    state_d   = S_DIFF;
                end
            end
            S_DIFF: begin
                sum_d   = add_y;
                state_d = S_DRIVE;
            end
            S_DRIVE: begin
                prod_d  = mul_y;
                state_d = S_SUM;
            end
            S_SUM: begin
                sum_d   = add_y;
                state_d = S_SCALE;
            end
            S_SCALE: begin
                prod_d  = mul_y;
                state_d = S_ACC;
            end
            S_ACC: begin
                sum_d   = add_y;
                state_d = S_CMP;
            end
            S_CMP: begin
                if (!(out_valid_q && !out_ready)) begin
                    out_valid_d = 1'b1;
                    state_d     = S_IDLE;
                    if (rc_q != '0) begin
                        rc_d    = rc_q - RW'(1);
                        v_out_d = v_q;
                        spike_d = 1'b0;
                    end else if (cmp_ge) begin
                        v_d     = v_reset_q;
                        v_out_d = v_reset_q;
                        spike_d = 1'b1;
                        rc_d    = refrac_q;
                    end else begin
                        v_d     = sum_q;
                        v_out_d = sum_q;
                        spike_d = 1'b0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            i_in_q      <= '0;
            v_rest_q    <= '0;
            v_reset_q   <= '0;
            v_th_q      <= '0;
            r_mem_q     <= '0;
            dt_tau_q    <= '0;
            refrac_q    <= '0;
            v_q         <= '0;
            rc_q        <= '0;
            sum_q       <= '0;
            prod_q      <= '0;
            out_valid_q <= 1'b0;
            v_out_q     <= '0;
            spike_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            i_in_q      <= i_in_d;
            v_rest_q    <= v_rest_d;
            v_reset_q   <= v_reset_d;
            v_th_q      <= v_th_d;
            r_mem_q     <= r_mem_d;
            dt_tau_q    <= dt_tau_d;
            refrac_q    <= refrac_d;
            v_q         <= v_d;
            rc_q        <= rc_d;
            sum_q       <= sum_d;
            prod_q      <= prod_d;
            out_valid_q <= out_valid_d;
            v_out_q     <= v_out_d;
            spike_q     <= spike_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = out_valid_q;
    assign v_out     = v_out_q;
    assign spike     = spike_q;

endmodule

// File: tb/tb_lif_step_unit.sv
// tb_lif_step_unit: directed and randomized checks of lif_step_unit against a step-level model.
// Expected results are queued in acceptance order and compared on every cycle out_valid is high.
// Backpressure is exercised both by directed stalls and by a randomized out_ready.
module tb_lif_step_unit;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] i_in, v_rest, v_reset, v_th, r_mem, dt_tau;
    logic [7:0]  refrac_steps;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] v_out;
    logic        spike;

    lif_step_unit #(.N(32), .Q(16), .RW(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .i_in         (i_in),
        .v_rest       (v_rest),
        .v_reset      (v_reset),
        .v_th         (v_th),
        .r_mem        (r_mem),
        .dt_tau       (dt_tau),
        .refrac_steps (refrac_steps),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .v_out        (v_out),
        .spike        (spike)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [32:0] exp_q[$];     // {spike, v_out} in acceptance order
    logic [31:0] mv;           // model membrane voltage
    logic [7:0]  mrc;          // model refractory count
    bit          rnd_bp = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- value-level model of the Q16.16 library ----------------
    function automatic longint sm2i(input logic [31:0] x);
        longint m;
        m = longint'(x[30:0]);
        return x[31] ? -m : m;
    endfunction

    function automatic logic [31:0] i2sm(input longint r);
        longint     a;
        logic [30:0] m;
        a = (r < 0) ? -r : r;
        m = a[30:0];
        if (m == 31'd0) return 32'h0;
        return {(r < 0), m};
    endfunction

    function automatic logic [31:0] sm_add(input logic [31:0] x, input logic [31:0] y);
        return i2sm(sm2i(x) + sm2i(y));
    endfunction

    function automatic logic [31:0] sm_mul(input logic [31:0] x, input logic [31:0] y);
        longint a, b, pr, sh;
        logic [30:0] m;
        a  = sm2i(x);
        b  = sm2i(y);
        pr = ((a < 0) ? -a : a) * ((b < 0) ? -b : b);
        sh = pr >>> 16;
        m  = sh[30:0];
        if (m == 31'd0) return 32'h0;
        return {((a < 0) != (b < 0)), m};
    endfunction

    // One Euler step on the current bench inputs; result is queued.
    task automatic model_accept();
        logic [31:0] d, p, s, q, vn, res;
        logic        spk;
        d  = sm_add(v_rest, i2sm(-sm2i(mv)));
        p  = sm_mul(r_mem, i_in);
        s  = sm_add(d, p);
        q  = sm_mul(dt_tau, s);
        vn = sm_add(mv, q);
        if (mrc != 8'd0) begin
            mrc = mrc - 8'd1;
            res = mv;
            spk = 1'b0;
        end else if (sm2i(vn) >= sm2i(v_th)) begin
            mv  = i2sm(sm2i(v_reset));
            res = mv;
            spk = 1'b1;
            mrc = refrac_steps;
        end else begin
            mv  = vn;
            res = vn;
            spk = 1'b0;
        end
        exp_q.push_back({spk, res});
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        mv  = 32'h0;
        mrc = 8'h0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Presents a sample only on a cycle where in_ready is already high, so the
    // accepting edge is always known; returns #1 after that edge.
    task automatic send(input logic [31:0] ii, input logic [31:0] vr, input logic [31:0] vrs,
                        input logic [31:0] vt, input logic [31:0] rm, input logic [31:0] dtt,
                        input logic [7:0] rf);
        bit ok;
        ok = 1'b0;
        for (int w = 0; w < 300; w++) begin
            @(negedge clk);
            if (in_ready) begin
                i_in = ii; v_rest = vr; v_reset = vrs; v_th = vt;
                r_mem = rm; dt_tau = dtt; refrac_steps = rf;
                in_valid = 1'b1;
                @(posedge clk);
                model_accept();
                ok = 1'b1;
                #1 in_valid = 1'b0;
                break;
            end
        end
        chk("accept_within_bound", 64'(ok), 64'd1);
    endtask

    // Called right after send(); checks busy/latency and literal result.
    task automatic expect_step(input string name, input logic [31:0] ev, input logic es);
        int lat;
        bit seen;
        lat  = 0;
        seen = 1'b0;
        while (lat < 30 && !seen) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (out_valid) seen = 1'b1;
            else chk({name, "_busy"}, 64'(in_ready), 64'd0);
        end
        chk({name, "_latency"}, 64'(lat), 64'd6);
        chk({name, "_v_out"}, 64'(v_out), 64'(ev));
        chk({name, "_spike"}, 64'(spike), 64'(es));
        chk({name, "_ready_after"}, 64'(in_ready), 64'd1);
    endtask

    function automatic logic [31:0] rnd_sm();
        logic [31:0] r;
        case ($urandom_range(0, 5))
            0: r = 32'h8000_0000;
            1: r = $urandom;
            default: begin
                r     = $urandom_range(0, 32'h0004_0000);
                r[31] = 1'($urandom_range(0, 1));
            end
        endcase
        return r;
    endfunction

    function automatic logic [31:0] rnd_gain();
        logic [31:0] r;
        if ($urandom_range(0, 7) == 0) r = $urandom;
        else r = $urandom_range(0, 32'h0002_0000);
        return r;
    endfunction

    // ---------------- compare process ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && out_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_out: out_valid=1 v_out=0x%0h with no result pending", v_out);
                end else begin
                    chk("model_v_out", 64'(v_out), 64'(exp_q[0][31:0]));
                    chk("model_spike", 64'(spike), 64'(exp_q[0][32]));
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    // Random backpressure while enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_bp) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        i_in = '0; v_rest = '0; v_reset = '0; v_th = '0; r_mem = '0; dt_tau = '0; refrac_steps = '0;
        mv = '0; mrc = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_v_out", 64'(v_out), 64'd0);
        chk("rst_spike", 64'(spike), 64'd0);

        // Basic step and repeat.
        send(32'h0002_0000, 32'h0, 32'h0, 32'h000A_0000, 32'h0001_0000, 32'h0000_8000, 8'd0);
        expect_step("basic1", 32'h0001_0000, 1'b0);
        send(32'h0002_0000, 32'h0, 32'h0, 32'h000A_0000, 32'h0001_0000, 32'h0000_8000, 8'd0);
        expect_step("basic2", 32'h0001_8000, 1'b0);

        // Spike then two refractory steps, then spike again.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            send(32'h0004_0000, 32'h0, 32'h8000_8000, 32'h0001_0000, 32'h0001_0000, 32'h0000_8000, 8'd2);
            expect_step($sformatf("spike_step%0d", k + 1), 32'h8000_8000, (k == 0 || k == 3));
        end

        // Threshold equality and one LSB above.
        do_reset();
        send(32'h0002_0000, 32'h0, 32'h0, 32'h0001_0000, 32'h0001_0000, 32'h0000_8000, 8'd0);
        expect_step("thr_equal", 32'h0, 1'b1);
        do_reset();
        send(32'h0002_0000, 32'h0, 32'h0, 32'h0001_0001, 32'h0001_0000, 32'h0000_8000, 8'd0);
        expect_step("thr_above", 32'h0001_0000, 1'b0);

        // Negative arithmetic, -0 inputs and an exact-zero result.
        do_reset();
        send(32'h8001_0000, 32'h8000_0000, 32'h0, 32'h0001_0000, 32'h0001_0000, 32'h0000_8000, 8'd0);
        expect_step("neg_half", 32'h8000_8000, 1'b0);
        send(32'h0000_8000, 32'h8000_0000, 32'h0, 32'h0001_0000, 32'h0001_0000, 32'h0000_8000, 8'd0);
        expect_step("zero_pos", 32'h0000_0000, 1'b0);

        // Backpressure: first result held, second stalls in CMP.
        do_reset();
        out_ready = 1'b0;
        send(32'h0002_0000, 32'h0, 32'h0, 32'h000A_0000, 32'h0001_0000, 32'h0000_8000, 8'd0);
        send(32'h0002_0000, 32'h0, 32'h0, 32'h000A_0000, 32'h0001_0000, 32'h0000_8000, 8'd0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("bp_stall_in_ready", 64'(in_ready), 64'd0);
        chk("bp_held_valid", 64'(out_valid), 64'd1);
        chk("bp_held_v_out", 64'(v_out), 64'h0001_0000);
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk("bp_second_v_out", 64'(v_out), 64'h0001_8000);
        chk("bp_second_valid", 64'(out_valid), 64'd1);
        chk("bp_second_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        repeat (3) @(posedge clk);

        // Reset in SCALE with a held spike result and a loaded refractory count.
        do_reset();
        out_ready = 1'b0;
        send(32'h0004_0000, 32'h0, 32'h8000_8000, 32'h0001_0000, 32'h0001_0000, 32'h0000_8000, 8'd2);
        expect_step("pre_reset_spike", 32'h8000_8000, 1'b1);
        send(32'h0002_0000, 32'h0, 32'h0, 32'h000A_0000, 32'h0001_0000, 32'h0000_8000, 8'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        exp_q.delete();
        mv  = '0;
        mrc = '0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_spike", 64'(spike), 64'd0);
        chk("midrst_v_out", 64'(v_out), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        send(32'h0002_0000, 32'h0, 32'h0, 32'h000A_0000, 32'h0001_0000, 32'h0000_8000, 8'd0);
        expect_step("post_reset", 32'h0001_0000, 1'b0);

        // Randomized samples with random backpressure and input gaps.
        do_reset();
        rnd_bp = 1'b1;
        for (int n = 0; n < 150; n++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            send(rnd_sm(), rnd_sm(), rnd_sm(), rnd_sm(), rnd_gain(), rnd_gain(),
                 8'($urandom_range(0, 3)));
        end
        rnd_bp = 1'b0;
        @(posedge clk);
        #1 out_ready = 1'b1;
        for (int w = 0; w < 200 && exp_q.size() != 0; w++) @(posedge clk);
        @(negedge clk);
        chk("drain_all_results", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
